// File: rtl/clk_div_gen.sv
// clk_div_gen: NCH independent programmable clock dividers / PWM generators.
// Each channel counts 0..P_act-1. It drives div_out high for the first H_act
// counts, and pulses tick and cfg_ld on every period start ("restart").
// New period/high values are sampled only at a restart, so a reload never
// glitches the output. A shared level-sensitive sync input restarts every
// enabled channel on the same edge.
//
// Handshake note: this block has no valid/ready traffic. en is a plain level
// qualifier per channel. tick and cfg_ld are single-cycle registered strobes
// that the consumer samples on the clock edge after they are raised.
module clk_div_gen #(
    parameter int NCH        = 2,
    parameter int CNT_W      = 16,
    parameter int RST_PERIOD = 50,
    parameter int RST_HIGH   = 25
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NCH-1:0]       en,
    input  logic [NCH*CNT_W-1:0] period,
    input  logic [NCH*CNT_W-1:0] high,
    input  logic                 sync,
    output logic [NCH-1:0]       div_out,
    output logic [NCH-1:0]       tick,
    output logic [NCH-1:0]       cfg_ld
);

    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
    localparam logic [CNT_W-1:0] RST_P_VAL = CNT_W'(RST_PERIOD);
    localparam logic [CNT_W-1:0] RST_H_VAL = CNT_W'(RST_HIGH);

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [CNT_W-1:0] per_req;
        logic [CNT_W-1:0] high_req;
        logic [CNT_W-1:0] per_eff;
        logic [CNT_W-1:0] cnt_inc;
        logic [CNT_W-1:0] cnt_q,   cnt_d;
        logic [CNT_W-1:0] p_act_q, p_act_d;
        logic [CNT_W-1:0] h_act_q, h_act_d;
        logic             en_prev_q;
        logic             div_q,  div_d;
        logic             tick_q, tick_d;
        logic             cfg_q,  cfg_d;
        logic             restart;

        assign per_req  = period[g*CNT_W +: CNT_W];
        assign high_req = high[g*CNT_W +: CNT_W];
        // A period shorter than 2 cannot produce a high and a low phase, so it is clamped.
        assign per_eff  = (per_req < TWO) ? TWO : per_req;
        // cnt_q never exceeds P_act-1 <= 2^CNT_W-2, so this increment cannot overflow.
        assign cnt_inc  = cnt_q + ONE;

        // A restart happens on an enable rise, at the end of a period, or on sync, and only while enabled.
        assign restart = en[g] && (!en_prev_q || (cnt_q == p_act_q - ONE) || sync);

        // Next-state selection: disabled, restart, or count within the period.
        always_comb begin
            cnt_d   = cnt_q;
            p_act_d = p_act_q;
            h_act_d = h_act_q;
            div_d   = 1'b0;
            tick_d  = 1'b0;
            cfg_d   = 1'b0;
            if (!en[g]) begin
                cnt_d = '0;
            end else if (restart) begin
                cnt_d   = '0;
                p_act_d = per_eff;
                h_act_d = high_req;
                tick_d  = 1'b1;
                cfg_d   = 1'b1;
                div_d   = (high_req != '0);
            end else begin
                cnt_d = cnt_inc;
                div_d = (cnt_inc < h_act_q);
            end
        end

        // Channel state registers with asynchronous active-low reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q     <= '0;
                p_act_q   <= RST_P_VAL;
                h_act_q   <= RST_H_VAL;
                en_prev_q <= 1'b0;
                div_q     <= 1'b0;
                tick_q    <= 1'b0;
                cfg_q     <= 1'b0;
            end else begin
                cnt_q     <= cnt_d;
                p_act_q   <= p_act_d;
                h_act_q   <= h_act_d;
                en_prev_q <= en[g];
                div_q     <= div_d;
                tick_q    <= tick_d;
                cfg_q     <= cfg_d;
            end
        end

        assign div_out[g] = div_q;
        assign tick[g]    = tick_q;
        assign cfg_ld[g]  = cfg_q;
    end

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed bench for clk_div_gen (NCH=2, CNT_W=16).
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that
// same point, after the edge has settled.
module tb_clk_div_gen;

    localparam int NCH   = 2;
    localparam int CNT_W = 16;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NCH-1:0]       en;
    logic [NCH*CNT_W-1:0] period;
    logic [NCH*CNT_W-1:0] high;
    logic                 sync;
    logic [NCH-1:0]       div_out;
    logic [NCH-1:0]       tick;
    logic [NCH-1:0]       cfg_ld;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  en;
        logic [15:0] p0, h0, p1, h1;
        logic        sync;
        logic [1:0]  div, tck, cfg;
    } vec_t;

    vec_t       tbl[$];
    logic [5:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    clk_div_gen #(.NCH(NCH), .CNT_W(CNT_W), .RST_PERIOD(50), .RST_HIGH(25)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .period  (period),
        .high    (high),
        .sync    (sync),
        .div_out (div_out),
        .tick    (tick),
        .cfg_ld  (cfg_ld)
    );

    // driver tasks
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] e, input logic [15:0] p0, input logic [15:0] h0,
                         input logic [15:0] p1, input logic [15:0] h1, input logic s);
        en     = e;
        period = {p1, p0};
        high   = {h1, h0};
        sync   = s;
    endtask

    // Channel 1 stays disabled in the table with a nonzero config, so its outputs must stay 0.
    task automatic add0(input logic e0, input logic [15:0] p0, input logic [15:0] h0, input logic s,
                        input logic d, input logic t, input logic c);
        vec_t v;
        v.en = {1'b0, e0};
        v.p0 = p0; v.h0 = h0; v.p1 = 16'd3; v.h1 = 16'd1;
        v.sync = s;
        v.div = {1'b0, d}; v.tck = {1'b0, t}; v.cfg = {1'b0, c};
        tbl.push_back(v);
    endtask

    task automatic do_reset();
        drive(2'b00, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);
        rst_n = 1'b0;
        repeat (2) step();
        check("reset_div", {30'd0, div_out}, 32'd0);
        check("reset_tick", {30'd0, tick}, 32'd0);
        check("reset_cfg", {30'd0, cfg_ld}, 32'd0);
        rst_n = 1'b1;
    endtask

    // scoreboard: pops the expected {div,tick,cfg} word and compares it with the DUT outputs
    task automatic score(input string tag);
        logic [5:0] e;
        e = exp_q.pop_front();
        check({tag, "_div"},  {30'd0, div_out}, {30'd0, e[5:4]});
        check({tag, "_tick"}, {30'd0, tick},    {30'd0, e[3:2]});
        check({tag, "_cfg"},  {30'd0, cfg_ld},  {30'd0, e[1:0]});
    endtask

    initial begin
        rst_n = 1'b0;
        drive(2'b00, 16'd0, 16'd0, 16'd0, 16'd0, 1'b0);

        // ---------------- table: reload, corner values, sync, enable ----------------
        add0(1, 5, 2, 0, 1, 1, 1);   // 0  enable rise: 5/2 latched
        add0(1, 5, 2, 0, 1, 0, 0);   // 1  cnt1
        add0(1, 8, 6, 0, 0, 0, 0);   // 2  change mid-period: ignored
        add0(1, 8, 6, 0, 0, 0, 0);   // 3
        add0(1, 8, 6, 0, 0, 0, 0);   // 4  cnt4
        add0(1, 8, 6, 0, 1, 1, 1);   // 5  restart latches 8/6
        for (int i = 0; i < 5; i++) add0(1, 8, 6, 0, 1, 0, 0);  // 6-10 cnt1..5
        add0(1, 0, 0, 0, 0, 0, 0);   // 11 cnt6
        add0(1, 0, 0, 0, 0, 0, 0);   // 12 cnt7
        add0(1, 0, 0, 0, 0, 1, 1);   // 13 period 0 -> 2, high 0
        add0(1, 1, 0, 0, 0, 0, 0);   // 14
        add0(1, 1, 0, 0, 0, 1, 1);   // 15 period 1 -> 2
        add0(1, 4, 7, 0, 0, 0, 0);   // 16
        add0(1, 4, 7, 0, 1, 1, 1);   // 17 high 7 >= period 4: constant high
        for (int i = 0; i < 3; i++) add0(1, 4, 7, 0, 1, 0, 0);  // 18-20
        add0(1, 4, 7, 0, 1, 1, 1);   // 21
        add0(1, 4, 7, 1, 1, 1, 1);   // 22 sync held: restart every cycle
        add0(1, 4, 7, 1, 1, 1, 1);   // 23
        add0(1, 4, 7, 0, 1, 0, 0);   // 24
        add0(0, 4, 7, 0, 0, 0, 0);   // 25 disabled
        add0(1, 5, 2, 0, 1, 1, 1);   // 26 re-enable
        add0(0, 5, 2, 1, 0, 0, 0);   // 27 en=0 overrides sync
        add0(1, 5, 2, 0, 1, 1, 1);   // 28
        add0(1, 5, 2, 0, 1, 0, 0);   // 29
        add0(1, 5, 2, 0, 0, 0, 0);   // 30
        add0(1, 5, 2, 0, 0, 0, 0);   // 31
        add0(1, 5, 2, 0, 0, 0, 0);   // 32 cnt4
        add0(1, 5, 2, 1, 1, 1, 1);   // 33 sync coincides with wrap: one restart
        add0(1, 5, 2, 0, 1, 0, 0);   // 34 cnt1, no second tick

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].p0, tbl[i].h0, tbl[i].p1, tbl[i].h1, tbl[i].sync);
            step();
            exp_q.push_back({tbl[i].div, tbl[i].tck, tbl[i].cfg});
            score($sformatf("vec%0d", i));
        end

        // ---------------- 50/25 on both channels ----------------
        do_reset();
        drive(2'b11, 16'd50, 16'd25, 16'd50, 16'd25, 1'b0);
        for (int k = 0; k < 150; k++) begin
            logic d, t;
            d = ((k % 50) < 25);
            t = ((k % 50) == 0);
            step();
            exp_q.push_back({d, d, t, t, t, t});
            score($sformatf("p50_k%0d", k));
        end

        // ---------------- sync alignment, en[0] drop and re-raise ----------------
        do_reset();
        drive(2'b01, 16'd10, 16'd5, 16'd15, 16'd7, 1'b0);
        repeat (3) step();
        drive(2'b11, 16'd10, 16'd5, 16'd15, 16'd7, 1'b0);
        repeat (4) step();
        for (int j = 0; j < 90; j++) begin
            logic e0, d0, t0, d1, t1;
            int   ph;
            e0 = !(j >= 64 && j < 67);
            drive({1'b1, e0}, 16'd10, 16'd5, 16'd15, 16'd7, (j == 0));
            ph = (j >= 67) ? (j - 67) : j;
            d0 = e0 && ((ph % 10) < 5);
            t0 = e0 && ((ph % 10) == 0);
            d1 = ((j % 15) < 7);
            t1 = ((j % 15) == 0);
            step();
            exp_q.push_back({d1, d0, t1, t0, t1, t0});
            score($sformatf("sync_j%0d", j));
        end

        // ---------------- asynchronous reset while div_out is high ----------------
        do_reset();
        drive(2'b01, 16'd10, 16'd5, 16'd10, 16'd5, 1'b0);
        repeat (2) step();
        check("pre_rst_div", {30'd0, div_out}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_div", {30'd0, div_out}, 32'd0);
        check("async_rst_tick", {30'd0, tick}, 32'd0);
        check("async_rst_cfg", {30'd0, cfg_ld}, 32'd0);
        repeat (2) begin
            step();
            exp_q.push_back(6'd0);
            score("in_rst");
        end
        drive(2'b00, 16'd10, 16'd5, 16'd10, 16'd5, 1'b0);
        rst_n = 1'b1;
        repeat (3) begin
            step();
            exp_q.push_back(6'd0);
            score("post_rst_idle");
        end
        drive(2'b01, 16'd10, 16'd5, 16'd10, 16'd5, 1'b0);
        step();
        exp_q.push_back(6'b01_01_01);
        score("post_rst_en");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
